c2f_chunk_writer: RTL and testbench

- Upstream neighbour of the C2F chunk consumer. Accepts the host-to-FPGA QW payload stream and writes it into the dual-port C2F chunk RAM, one chunk at a time.
- Owns the C2F ring indices: it publishes wrIndex/rdIndex to the consumer and advances rdIndex on the consumer's dtAck.
- Also emits a per-chunk free pulse, used for host credit return.

---
 rtl/c2f_chunk_writer_pkg.sv | 25 ++
 rtl/c2f_chunk_writer_if.sv | 35 +++
 rtl/c2f_chunk_writer_ring_ctrl.sv | 51 +++++
 rtl/c2f_chunk_writer.sv | 96 +++++++++
 tb/tb_c2f_chunk_writer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/c2f_chunk_writer_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// c2f_chunk_writer_pkg : C2F chunk ring types (index, offset, RAM address)
// Revision: 1.0
// -----------------------------------------------------------------------------
package c2f_chunk_writer_pkg;

  localparam int C2F_CHUNKSIZE = 64;
  localparam int C2F_IDXW      = 2;
  localparam int C2F_OFFW      = $clog2(C2F_CHUNKSIZE / 8);

  typedef logic [31:0]           uint32;
  typedef logic [63:0]           uint64;
  typedef logic [C2F_IDXW-1:0]   C2FChunkIndex;
  typedef logic [C2F_OFFW-1:0]   C2FChunkOffset;

  localparam int C2F_NUMCHUNKS = 2 ** $bits(C2FChunkIndex);

  typedef struct packed {
    C2FChunkIndex  index;
    C2FChunkOffset offset;
  } C2FRamAddr;

endpackage
`default_nettype wire

// File: rtl/c2f_chunk_writer_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// c2f_chunk_writer_if : payload stream, chunk RAM write port and ring indices
// Revision: 1.0
// -----------------------------------------------------------------------------
interface c2f_chunk_writer_if;
  import c2f_chunk_writer_pkg::*;

  logic         qwValid_in;
  uint64        qwData_in;
  logic         qwReady_out;
  logic         ramWrEnable_out;
  C2FRamAddr    ramWrAddr_out;
  uint64        ramWrData_out;
  C2FChunkIndex wrIndex_out;
  C2FChunkIndex rdIndex_out;
  logic         dtAck_in;
  logic         chunkFreed_out;
  logic         ovfErr_out;
  uint32        chunkCount_out;

  modport master (
    output qwValid_in, qwData_in, dtAck_in,
    input  qwReady_out, ramWrEnable_out, ramWrAddr_out, ramWrData_out,
           wrIndex_out, rdIndex_out, chunkFreed_out, ovfErr_out, chunkCount_out
  );

  modport slave (
    input  qwValid_in, qwData_in, dtAck_in,
    output qwReady_out, ramWrEnable_out, ramWrAddr_out, ramWrData_out,
           wrIndex_out, rdIndex_out, chunkFreed_out, ovfErr_out, chunkCount_out
  );

endinterface
`default_nettype wire

// File: rtl/c2f_chunk_writer_ring_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// c2f_ring_ctrl : C2F ring write/read indices, full/empty decode, free pulse
// Revision: 1.0
// -----------------------------------------------------------------------------
module c2f_ring_ctrl
  import c2f_chunk_writer_pkg::*;
(
  input  wire logic   sysClk_in,
  input  wire logic   sysReset_in,
  input  wire logic   i_commit,
  input  wire logic   i_dtAck,
  output C2FChunkIndex o_wrIndex,
  output C2FChunkIndex o_rdIndex,
  output logic         o_full,
  output logic         o_chunkFreed
);

  C2FChunkIndex r_wrIndex;
  C2FChunkIndex r_rdIndex;
  logic         r_chunkFreed;
  logic         w_empty;
  logic         w_ackOk;

  // One slot is always left empty so full and empty remain distinguishable.
  assign w_empty = (r_wrIndex == r_rdIndex);
  assign o_full  = (C2FChunkIndex'(r_wrIndex + 1'b1) == r_rdIndex);
  assign w_ackOk = i_dtAck & ~w_empty;

  always_ff @(posedge sysClk_in or posedge sysReset_in) begin
    if (sysReset_in) begin
      r_wrIndex    <= '0;
      r_rdIndex    <= '0;
      r_chunkFreed <= 1'b0;
    end else begin
      if (i_commit) begin
        r_wrIndex <= C2FChunkIndex'(r_wrIndex + 1'b1);
      end
      if (w_ackOk) begin
        r_rdIndex <= C2FChunkIndex'(r_rdIndex + 1'b1);
      end
      r_chunkFreed <= w_ackOk;
    end
  end

  assign o_wrIndex    = r_wrIndex;
  assign o_rdIndex    = r_rdIndex;
  assign o_chunkFreed = r_chunkFreed;

endmodule
`default_nettype wire

// File: rtl/c2f_chunk_writer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// c2f_chunk_writer : writes the host QW stream into the C2F chunk RAM
// Revision: 1.0
// -----------------------------------------------------------------------------
module c2f_chunk_writer
  import c2f_chunk_writer_pkg::*;
(
  input wire logic          sysClk_in,
  input wire logic          sysReset_in,
  c2f_chunk_writer_if.slave bus
);

  localparam logic [0:0] S_FILL   = 1'b0;
  localparam logic [0:0] S_COMMIT = 1'b1;

  logic [0:0]    r_state;
  C2FChunkOffset r_offset;
  logic          r_ramWrEnable;
  C2FRamAddr     r_ramWrAddr;
  uint64         r_ramWrData;
  logic          r_ovfErr;
  uint32         r_chunkCount;

  C2FChunkIndex  w_wrIndex;
  C2FChunkIndex  w_rdIndex;
  logic          w_full;
  logic          w_chunkFreed;
  logic          w_qwReady;
  logic          w_xfer;
  logic          w_commit;

  assign w_qwReady = (r_state == S_FILL) & ~w_full;
  assign w_xfer    = bus.qwValid_in & w_qwReady;
  // The commit cycle lets the last RAM write land before wrIndex advances.
  assign w_commit  = (r_state == S_COMMIT);

  c2f_ring_ctrl u_ringCtrl (
    .sysClk_in    (sysClk_in),
    .sysReset_in  (sysReset_in),
    .i_commit     (w_commit),
    .i_dtAck      (bus.dtAck_in),
    .o_wrIndex    (w_wrIndex),
    .o_rdIndex    (w_rdIndex),
    .o_full       (w_full),
    .o_chunkFreed (w_chunkFreed)
  );

  always_ff @(posedge sysClk_in or posedge sysReset_in) begin
    if (sysReset_in) begin
      r_state       <= S_FILL;
      r_offset      <= '0;
      r_ramWrEnable <= 1'b0;
      r_ramWrAddr   <= '0;
      r_ramWrData   <= '0;
      r_ovfErr      <= 1'b0;
      r_chunkCount  <= '0;
    end else begin
      r_ramWrEnable <= w_xfer;
      if (w_xfer) begin
        r_ramWrAddr <= '{index: w_wrIndex, offset: r_offset};
        r_ramWrData <= bus.qwData_in;
      end
      if (bus.qwValid_in & ~w_qwReady) begin
        r_ovfErr <= 1'b1;
      end
      case (r_state)
        S_FILL: begin
          if (w_xfer) begin
            r_offset <= C2FChunkOffset'(r_offset + 1'b1);
            if (r_offset == '1) begin
              r_state <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          r_state      <= S_FILL;
          r_chunkCount <= r_chunkCount + 32'd1;
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign bus.qwReady_out     = w_qwReady;
  assign bus.ramWrEnable_out = r_ramWrEnable;
  assign bus.ramWrAddr_out   = r_ramWrAddr;
  assign bus.ramWrData_out   = r_ramWrData;
  assign bus.wrIndex_out     = w_wrIndex;
  assign bus.rdIndex_out     = w_rdIndex;
  assign bus.chunkFreed_out  = w_chunkFreed;
  assign bus.ovfErr_out      = r_ovfErr;
  assign bus.chunkCount_out  = r_chunkCount;

endmodule
`default_nettype wire

// File: tb/tb_c2f_chunk_writer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_c2f_chunk_writer : directed stimulus against a chunk/credit-count model
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_c2f_chunk_writer;
  import c2f_chunk_writer_pkg::*;

  localparam int N   = C2F_NUMCHUNKS;
  localparam int QPC = C2F_CHUNKSIZE / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  c2f_chunk_writer_if bus ();

  c2f_chunk_writer dut (
    .sysClk_in   (clk),
    .sysReset_in (rst),
    .bus         (bus)
  );

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: chunks counted as totals committed/freed; indices are those modulo N.
  int          mCommitted, mFreed, mQw;
  bit          mPending, mOvf, mWrEn, mFreedPulse;
  int          mAddr;
  logic [63:0] mData;
  bit          mRdy, mXfer, mAck;

  function automatic bit mReady();
    return !mPending && ((mCommitted - mFreed) < N - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCommitted = 0; mFreed = 0; mQw = 0; mPending = 0; mOvf = 0;
      mWrEn = 0; mFreedPulse = 0; mAddr = 0; mData = '0;
    end else begin
      mRdy  = mReady();
      mXfer = bus.qwValid_in && mRdy;
      mAck  = bus.dtAck_in && (mCommitted != mFreed);
      if (bus.qwValid_in && !mRdy) mOvf = 1;
      mWrEn = mXfer;
      if (mXfer) begin
        mAddr = (mCommitted % N) * QPC + mQw;
        mData = bus.qwData_in;
      end
      mFreedPulse = mAck;
      if (mAck) mFreed++;
      if (mPending) mCommitted++;
      mPending = mXfer && (mQw == QPC - 1);
      if (mXfer) mQw = (mQw + 1) % QPC;
    end
  end

  always @(posedge clk) begin
    #1;
    check("qwReady", bus.qwReady_out, mReady());
    check("ramWrEnable", bus.ramWrEnable_out, mWrEn);
    if (mWrEn) begin
      check("ramWrAddr", bus.ramWrAddr_out, mAddr);
      check("ramWrData", bus.ramWrData_out, mData);
    end
    check("wrIndex", bus.wrIndex_out, mCommitted % N);
    check("rdIndex", bus.rdIndex_out, mFreed % N);
    check("chunkFreed", bus.chunkFreed_out, mFreedPulse);
    check("ovfErr", bus.ovfErr_out, mOvf);
    check("chunkCount", bus.chunkCount_out, 32'(mCommitted));
  end

  task automatic waitReady(output bit ok);
    int budget = 200;
    ok = 1;
    while (!bus.qwReady_out) begin
      if (budget == 0) begin
        check("readyTimeout", 0, 1);
        ok = 0;
        return;
      end
      budget--;
      @(negedge clk);
    end
  endtask

  task automatic streamQws(input logic [63:0] base, input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      waitReady(ok);
      if (!ok) break;
      bus.qwValid_in = 1'b1;
      bus.qwData_in  = base + 64'(i);
      @(negedge clk);
      bus.qwValid_in = 1'b0;
    end
  endtask

  task automatic pulseAck();
    bus.dtAck_in = 1'b1;
    @(negedge clk);
    bus.dtAck_in = 1'b0;
  endtask

  task automatic asyncReset();
    #2 rst = 1'b1;
    #1;
    check("rstWrEn", bus.ramWrEnable_out, 0);
    check("rstWrIndex", bus.wrIndex_out, 0);
    check("rstRdIndex", bus.rdIndex_out, 0);
    check("rstOvfErr", bus.ovfErr_out, 0);
    check("rstChunkCount", bus.chunkCount_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.qwValid_in = 1'b0;
    bus.qwData_in  = '0;
    bus.dtAck_in   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("initReady", bus.qwReady_out, 1);
    check("initWrIndex", bus.wrIndex_out, 0);
    check("initCount", bus.chunkCount_out, 0);

    // Single chunk, back-to-back
    streamQws(64'd1, QPC);
    check("lastWrEn", bus.ramWrEnable_out, 1);
    check("lastWrAddr", bus.ramWrAddr_out, 7);
    check("lastWrData", bus.ramWrData_out, 8);
    check("commitWrIndex", bus.wrIndex_out, 0);
    check("commitReady", bus.qwReady_out, 0);
    @(negedge clk);
    check("pubWrIndex", bus.wrIndex_out, 1);
    check("pubCount", bus.chunkCount_out, 1);

    // Fill to full, then release one slot
    streamQws(64'd100, QPC);
    streamQws(64'd200, QPC);
    @(negedge clk);
    check("fullWrIndex", bus.wrIndex_out, 3);
    check("fullReady", bus.qwReady_out, 0);
    repeat (3) @(negedge clk);
    check("fullHold", bus.qwReady_out, 0);
    pulseAck();
    check("ackRdIndex", bus.rdIndex_out, 1);
    check("ackFreed", bus.chunkFreed_out, 1);
    check("ackReady", bus.qwReady_out, 1);
    streamQws(64'd300, 1);
    check("resumeAddr", bus.ramWrAddr_out, 24);
    check("resumeData", bus.ramWrData_out, 300);
    streamQws(64'd301, QPC - 1);
    @(negedge clk);
    check("wrapWrIndex", bus.wrIndex_out, 0);
    check("refullReady", bus.qwReady_out, 0);

    // Overflow while full
    bus.qwValid_in = 1'b1;
    bus.qwData_in  = 64'hDEAD;
    repeat (3) @(negedge clk);
    check("ovfSet", bus.ovfErr_out, 1);
    check("ovfNoWrite", bus.ramWrEnable_out, 0);
    bus.qwValid_in = 1'b0;
    repeat (2) @(negedge clk);
    check("ovfSticky", bus.ovfErr_out, 1);
    asyncReset();

    // Spurious ack when empty
    pulseAck();
    check("spurRdIndex", bus.rdIndex_out, 0);
    check("spurFreed", bus.chunkFreed_out, 0);

    // Ack in the same cycle as a commit
    streamQws(64'd400, QPC);
    @(negedge clk);
    streamQws(64'd500, QPC);
    pulseAck();
    check("simWrIndex", bus.wrIndex_out, 2);
    check("simRdIndex", bus.rdIndex_out, 1);
    check("simFreed", bus.chunkFreed_out, 1);
    asyncReset();

    // Wrap-around with a delayed ack per chunk
    for (int c = 0; c < 3 * N; c++) begin
      streamQws(64'(1000 + c * QPC), QPC);
      repeat (10) @(negedge clk);
      pulseAck();
    end
    @(negedge clk);
    check("wrapCount", bus.chunkCount_out, 12);
    check("wrapWrIdx", bus.wrIndex_out, 0);
    check("wrapRdIdx", bus.rdIndex_out, 0);
    check("wrapOvf", bus.ovfErr_out, 0);
    asyncReset();

    // Reset mid-chunk, then a fresh chunk from {0,0}
    streamQws(64'd50, 5);
    asyncReset();
    streamQws(64'd100, 1);
    check("freshWrEn", bus.ramWrEnable_out, 1);
    check("freshAddr", bus.ramWrAddr_out, 0);
    check("freshData", bus.ramWrData_out, 100);
    streamQws(64'd101, QPC - 1);
    repeat (2) @(negedge clk);
    check("freshWrIndex", bus.wrIndex_out, 1);
    check("freshCount", bus.chunkCount_out, 1);

    @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
